// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ID_REQ,
      ID_WAIT,
      TS_REQ,
      TS_WAIT,
      DONE
   } state_e;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;
   localparam int   TMO_W   = 16;

   // A check is in flight in any request or wait state.
   function automatic logic is_active(input state_e s);
      return (s == ID_REQ) || (s == ID_WAIT) || (s == TS_REQ) || (s == TS_WAIT);
   endfunction

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the system-ID slave.
interface sysid_checker_if;

   logic        avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;

   modport master (
      output avm_address, avm_read,
      input  avm_readdata, avm_waitrequest, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_read,
      output avm_readdata, avm_waitrequest, avm_readdatavalid
   );

endinterface

// File: rtl/avalon_read_ctrl.sv
// Single-word Avalon-MM read engine: request/acceptance, data qualification and per-transaction timeout.
module avalon_read_ctrl
   import sysid_pkg::*;
#(
   parameter bit USE_READDATAVALID = 1'b0,
   parameter int TIMEOUT_CYCLES    = 255
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req,
   input  logic            waiting,
   input  logic            address,
   sysid_checker_if.master avm,
   output logic            accepted,
   output logic            data_valid,
   output logic            timed_out,
   output logic [31:0]     data
);

   logic [TMO_W-1:0] count;
   logic             active;

   assign active          = req | waiting;
   assign avm.avm_read    = req;
   assign avm.avm_address = address;
   assign accepted        = req & ~avm.avm_waitrequest;
   assign data            = avm.avm_readdata;

   // Fixed-latency slaves present data in the acceptance cycle; pipelined ones only while we wait.
   assign data_valid = USE_READDATAVALID ? (waiting & avm.avm_readdatavalid) : accepted;

   // A capture on the last allowed cycle still counts as success.
   assign timed_out = active & ~data_valid & (count == TMO_W'(TIMEOUT_CYCLES - 1));

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset || !active || data_valid || timed_out) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sysid_checker.sv
// Boot-time check: reads the system-ID and timestamp words and compares them with build-time values.
module sysid_checker
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID       = 32'd0,
   parameter logic [31:0] EXPECTED_TS       = 32'd1586464125,
   parameter bit          CHECK_TS          = 1'b1,
   parameter bit          USE_READDATAVALID = 1'b0,
   parameter bit          AUTO_START        = 1'b1,
   parameter int          TIMEOUT_CYCLES    = 255
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   sysid_checker_if.master avm,
   output logic            busy,
   output logic            done,
   output logic            id_ok,
   output logic            ts_ok,
   output logic            timeout,
   output logic [31:0]     id_value,
   output logic [31:0]     ts_value
);

   state_e      state, next_state, after_capture;
   logic        auto_pending;
   logic        in_id, in_ts, launch;
   logic        accepted, data_valid, timed_out;
   logic [31:0] data;

   assign in_id  = (state == ID_REQ) || (state == ID_WAIT);
   assign in_ts  = (state == TS_REQ) || (state == TS_WAIT);
   assign launch = !is_active(state) && (next_state == ID_REQ);

   avalon_read_ctrl #(
      .USE_READDATAVALID (USE_READDATAVALID),
      .TIMEOUT_CYCLES    (TIMEOUT_CYCLES)
   ) u_read (
      .clock      (clock),
      .reset      (reset),
      .req        ((state == ID_REQ) || (state == TS_REQ)),
      .waiting    ((state == ID_WAIT) || (state == TS_WAIT)),
      .address    (in_ts ? ADDR_TS : ADDR_ID),
      .avm        (avm),
      .accepted   (accepted),
      .data_valid (data_valid),
      .timed_out  (timed_out),
      .data       (data)
   );

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      next_state    = state;
      after_capture = (in_id && CHECK_TS) ? TS_REQ : DONE;
      case (state)
         IDLE, DONE: begin
            if (start || auto_pending) next_state = ID_REQ;
         end
         ID_REQ, TS_REQ: begin
            if (data_valid)     next_state = after_capture;
            else if (timed_out) next_state = DONE;
            else if (accepted)  next_state = in_id ? ID_WAIT : TS_WAIT;
         end
         ID_WAIT, TS_WAIT: begin
            if (data_valid)     next_state = after_capture;
            else if (timed_out) next_state = DONE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         auto_pending <= AUTO_START;
         busy         <= 1'b0;
         done         <= 1'b0;
         id_ok        <= 1'b0;
         ts_ok        <= 1'b0;
         timeout      <= 1'b0;
         id_value     <= '0;
         ts_value     <= '0;
      end else begin
         state        <= next_state;
         auto_pending <= 1'b0;
         busy         <= is_active(next_state);
         done         <= (next_state == DONE);
         if (launch) begin
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
         end
         if (data_valid && in_id) begin
            id_value <= data;
            id_ok    <= (data == EXPECTED_ID);
            if (!CHECK_TS) ts_ok <= 1'b1;
         end
         if (data_valid && in_ts) begin
            ts_value <= data;
            ts_ok    <= (data == EXPECTED_TS);
         end
         if (timed_out) timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench: three checker instances (fixed-latency, pipelined, short timeout) against small slave models.
module tb_sysid_checker;

   localparam logic [31:0] TS_GOOD = 32'd1586464125;
   localparam logic [31:0] TS_BAD  = 32'd1586464126;
   localparam logic [31:0] B_ID    = 32'h1234_5678;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic a_start = 1'b0, b_start = 1'b0, c_start = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   sysid_checker_if a_if ();
   sysid_checker_if b_if ();
   sysid_checker_if c_if ();

   logic a_busy, a_done, a_id_ok, a_ts_ok, a_timeout;
   logic b_busy, b_done, b_id_ok, b_ts_ok, b_timeout;
   logic c_busy, c_done, c_id_ok, c_ts_ok, c_timeout;
   logic [31:0] a_id_value, a_ts_value, b_id_value, b_ts_value, c_id_value, c_ts_value;

   sysid_checker dut_a (
      .clock (clock), .reset (reset), .start (a_start), .avm (a_if.master),
      .busy (a_busy), .done (a_done), .id_ok (a_id_ok), .ts_ok (a_ts_ok),
      .timeout (a_timeout), .id_value (a_id_value), .ts_value (a_ts_value)
   );

   sysid_checker #(.EXPECTED_ID (B_ID), .USE_READDATAVALID (1'b1), .AUTO_START (1'b0)) dut_b (
      .clock (clock), .reset (reset), .start (b_start), .avm (b_if.master),
      .busy (b_busy), .done (b_done), .id_ok (b_id_ok), .ts_ok (b_ts_ok),
      .timeout (b_timeout), .id_value (b_id_value), .ts_value (b_ts_value)
   );

   sysid_checker #(.AUTO_START (1'b0), .TIMEOUT_CYCLES (10)) dut_c (
      .clock (clock), .reset (reset), .start (c_start), .avm (c_if.master),
      .busy (c_busy), .done (c_done), .id_ok (c_id_ok), .ts_ok (c_ts_ok),
      .timeout (c_timeout), .id_value (c_id_value), .ts_value (c_ts_value)
   );

   // Slave A: combinational data, waitrequest held for a_stall cycles on every read.
   logic [31:0] a_ts_word = TS_GOOD;
   int a_stall = 0;
   int a_wcnt  = 0;
   assign a_if.avm_waitrequest   = a_if.avm_read && (a_wcnt < a_stall);
   assign a_if.avm_readdata      = a_if.avm_address ? a_ts_word : 32'd0;
   assign a_if.avm_readdatavalid = 1'b0;
   always @(posedge clock) begin
      if (a_if.avm_read && a_if.avm_waitrequest) a_wcnt <= a_wcnt + 1;
      else a_wcnt <= 0;
   end

   // Slave B: pipelined, data returned three cycles after acceptance; b_spur injects stray valids.
   logic [2:0] b_pv = '0;
   logic [2:0] b_pa = '0;
   logic       b_spur = 1'b0;
   assign b_if.avm_waitrequest   = 1'b0;
   assign b_if.avm_readdatavalid = b_pv[2] | b_spur;
   assign b_if.avm_readdata      = b_pv[2] ? (b_pa[2] ? TS_GOOD : B_ID) : 32'hDEAD_BEEF;
   always @(posedge clock) begin
      b_pv <= {b_pv[1:0], b_if.avm_read && !b_if.avm_waitrequest};
      b_pa <= {b_pa[1:0], b_if.avm_address};
   end

   // Slave C: never accepts.
   assign c_if.avm_waitrequest   = 1'b1;
   assign c_if.avm_readdata      = 32'd0;
   assign c_if.avm_readdatavalid = 1'b0;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   // Leaves the bench at the negedge of the first busy cycle.
   task automatic pulse(input int which);
      if (which == 0) a_start = 1'b1; else if (which == 1) b_start = 1'b1; else c_start = 1'b1;
      tick(1);
      a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
   endtask

   task automatic test_reset;
      tick(2);
      checks++; if ({a_busy, a_done, a_id_ok, a_ts_ok, a_timeout} !== 5'b0) begin errors++; $display("FAIL reset_a_flags got=%b exp=00000", {a_busy, a_done, a_id_ok, a_ts_ok, a_timeout}); end
      checks++; if ({b_busy, b_done, b_id_ok, b_ts_ok, b_timeout} !== 5'b0) begin errors++; $display("FAIL reset_b_flags got=%b exp=00000", {b_busy, b_done, b_id_ok, b_ts_ok, b_timeout}); end
      checks++; if ({c_busy, c_done, c_id_ok, c_ts_ok, c_timeout} !== 5'b0) begin errors++; $display("FAIL reset_c_flags got=%b exp=00000", {c_busy, c_done, c_id_ok, c_ts_ok, c_timeout}); end
      checks++; if ({a_id_value, a_ts_value} !== 64'd0) begin errors++; $display("FAIL reset_a_values got=%h exp=0", {a_id_value, a_ts_value}); end
      checks++; if ({a_if.avm_read, b_if.avm_read, c_if.avm_read} !== 3'b0) begin errors++; $display("FAIL reset_read got=%b exp=000", {a_if.avm_read, b_if.avm_read, c_if.avm_read}); end
   endtask

   task automatic test_auto_start;
      reset = 1'b0;
      tick(2);
      checks++; if ({a_busy, a_done} !== 2'b10) begin errors++; $display("FAIL auto_cycle2 busy/done got=%b exp=10", {a_busy, a_done}); end
      checks++; if ({a_if.avm_read, a_if.avm_address} !== 2'b11) begin errors++; $display("FAIL auto_cycle2 read/addr got=%b exp=11", {a_if.avm_read, a_if.avm_address}); end
      tick(1);
      checks++; if ({a_busy, a_done, a_id_ok, a_ts_ok, a_timeout} !== 5'b01110) begin errors++; $display("FAIL auto_done flags got=%b exp=01110", {a_busy, a_done, a_id_ok, a_ts_ok, a_timeout}); end
      checks++; if (a_ts_value !== TS_GOOD) begin errors++; $display("FAIL auto_ts_value got=%0d exp=%0d", a_ts_value, TS_GOOD); end
      checks++; if ({b_busy, c_busy} !== 2'b00) begin errors++; $display("FAIL no_auto_start busy got=%b exp=00", {b_busy, c_busy}); end
   endtask

   task automatic test_wait_stall;
      a_stall = 4;
      pulse(0);
      for (int k = 1; k <= 10; k++) begin
         checks++; if ({a_if.avm_read, a_if.avm_address} !== {1'b1, k >= 6}) begin errors++; $display("FAIL stall_cycle%0d read/addr got=%b exp=%b", k, {a_if.avm_read, a_if.avm_address}, {1'b1, k >= 6}); end
         checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL stall_cycle%0d done got=%b exp=0", k, a_done); end
         tick(1);
      end
      checks++; if ({a_done, a_id_ok, a_ts_ok, a_timeout} !== 4'b1110) begin errors++; $display("FAIL stall_done flags got=%b exp=1110", {a_done, a_id_ok, a_ts_ok, a_timeout}); end
      a_stall = 0;
   endtask

   task automatic test_ts_mismatch;
      a_ts_word = TS_BAD;
      pulse(0);
      tick(2);
      checks++; if ({a_done, a_id_ok, a_ts_ok, a_timeout} !== 4'b1100) begin errors++; $display("FAIL ts_bad flags got=%b exp=1100", {a_done, a_id_ok, a_ts_ok, a_timeout}); end
      checks++; if (a_ts_value !== TS_BAD) begin errors++; $display("FAIL ts_bad value got=%0d exp=%0d", a_ts_value, TS_BAD); end
   endtask

   task automatic test_readdatavalid;
      b_spur = 1'b1;
      tick(1);
      b_spur = 1'b0;
      checks++; if ({b_busy, b_done, b_id_value} !== 34'd0) begin errors++; $display("FAIL rdv_idle got=%h exp=0", {b_busy, b_done, b_id_value}); end
      pulse(1);
      b_spur = 1'b1;
      checks++; if ({b_if.avm_read, b_if.avm_address} !== 2'b10) begin errors++; $display("FAIL rdv_id_req read/addr got=%b exp=10", {b_if.avm_read, b_if.avm_address}); end
      tick(1);
      b_spur = 1'b0;
      checks++; if ({b_if.avm_read, b_busy} !== 2'b01) begin errors++; $display("FAIL rdv_id_wait read/busy got=%b exp=01", {b_if.avm_read, b_busy}); end
      tick(3);
      checks++; if ({b_id_value, b_id_ok} !== {B_ID, 1'b1}) begin errors++; $display("FAIL rdv_id_capture got=%h/%b exp=%h/1", b_id_value, b_id_ok, B_ID); end
      checks++; if ({b_if.avm_read, b_if.avm_address} !== 2'b11) begin errors++; $display("FAIL rdv_ts_req read/addr got=%b exp=11", {b_if.avm_read, b_if.avm_address}); end
      tick(3);
      checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL rdv_cycle8 done got=%b exp=0", b_done); end
      tick(1);
      checks++; if ({b_busy, b_done, b_id_ok, b_ts_ok, b_timeout} !== 5'b01110) begin errors++; $display("FAIL rdv_done flags got=%b exp=01110", {b_busy, b_done, b_id_ok, b_ts_ok, b_timeout}); end
      checks++; if (b_ts_value !== TS_GOOD) begin errors++; $display("FAIL rdv_ts_value got=%0d exp=%0d", b_ts_value, TS_GOOD); end
   endtask

   task automatic test_timeout;
      pulse(2);
      tick(9);
      checks++; if ({c_busy, c_done, c_if.avm_read} !== 3'b101) begin errors++; $display("FAIL tmo_cycle10 busy/done/read got=%b exp=101", {c_busy, c_done, c_if.avm_read}); end
      tick(1);
      checks++; if ({c_busy, c_done, c_id_ok, c_ts_ok, c_timeout} !== 5'b01001) begin errors++; $display("FAIL tmo_done flags got=%b exp=01001", {c_busy, c_done, c_id_ok, c_ts_ok, c_timeout}); end
      checks++; if (c_if.avm_read !== 1'b0) begin errors++; $display("FAIL tmo_read_drop got=%b exp=0", c_if.avm_read); end
      tick(3);
      checks++; if ({c_if.avm_read, c_done, c_timeout} !== 3'b011) begin errors++; $display("FAIL tmo_hold read/done/timeout got=%b exp=011", {c_if.avm_read, c_done, c_timeout}); end
   endtask

   task automatic test_reset_mid;
      pulse(1);
      tick(5);
      checks++; if ({b_busy, b_if.avm_read, b_if.avm_address, b_id_ok} !== 4'b1011) begin errors++; $display("FAIL mid_ts_wait busy/read/addr/id_ok got=%b exp=1011", {b_busy, b_if.avm_read, b_if.avm_address, b_id_ok}); end
      reset = 1'b1;
      tick(1);
      checks++; if ({b_busy, b_done, b_id_ok, b_if.avm_read, b_id_value} !== 36'd0) begin errors++; $display("FAIL mid_reset_clear got=%h exp=0", {b_busy, b_done, b_id_ok, b_if.avm_read, b_id_value}); end
      checks++; if (c_timeout !== 1'b0) begin errors++; $display("FAIL mid_reset_c_timeout got=%b exp=0", c_timeout); end
      reset = 1'b0;
      tick(2);
      checks++; if ({b_busy, b_done, b_id_value, b_ts_value} !== 66'd0) begin errors++; $display("FAIL mid_stale_rdv got=%h exp=0", {b_busy, b_done, b_id_value, b_ts_value}); end
      pulse(1);
      checks++; if ({b_if.avm_read, b_if.avm_address} !== 2'b10) begin errors++; $display("FAIL mid_restart read/addr got=%b exp=10", {b_if.avm_read, b_if.avm_address}); end
      tick(8);
      checks++; if ({b_done, b_id_ok, b_ts_ok, b_timeout} !== 4'b1110) begin errors++; $display("FAIL mid_restart_done flags got=%b exp=1110", {b_done, b_id_ok, b_ts_ok, b_timeout}); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      @(negedge clock);
      test_reset;
      test_auto_start;
      test_wait_stall;
      test_ts_mismatch;
      test_readdatavalid;
      test_timeout;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM read master; the initiator end of the system-ID slave interface.
- After reset, or on a start pulse, it reads the ID word (address 0) and then the timestamp word (address 1), with full waitrequest/readdatavalid handshaking.
- It compares each word against the build-time expected values and reports pass, fail or timeout.
- Sits beside the Nios II subsystem as a boot-time sanity check, so the wrong bitstream/software pairing can be flagged (e.g. on an LED).

Parameters:
EXPECTED_ID, 32'd0, expected value at address 0
EXPECTED_TS, 32'd1586464125, expected value at address 1
CHECK_TS, 1, 1 = read and compare the timestamp; 0 = ID only
USE_READDATAVALID, 0, 1 = pipelined slave, data qualified by avm_readdatavalid; 0 = fixed-latency slave, data captured in the acceptance cycle
AUTO_START, 1, 1 = start one check automatically in the first cycle after reset deasserts
TIMEOUT_CYCLES, 255, maximum cycles allowed per transaction (request plus wait); range 1..65535

Ports:
clock  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that requests a check
avm_address  out  1  word address: 0 = ID, 1 = timestamp
avm_read  out  1  read request
avm_readdata  in  32  read data from the slave
avm_waitrequest  in  1  slave stall
avm_readdatavalid  in  1  read data valid; used only when USE_READDATAVALID=1
busy  out  1  check in progress
done  out  1  result valid; held until the next start or reset
id_ok  out  1  captured ID equals EXPECTED_ID
ts_ok  out  1  captured timestamp equals EXPECTED_TS; forced to 1 when CHECK_TS=0
timeout  out  1  a transaction exceeded TIMEOUT_CYCLES
id_value  out  32  captured ID word
ts_value  out  32  captured timestamp word

Behaviour:
- Clock/reset (already decided): one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, id_value/ts_value 0, FSM in IDLE.
- Reset asserted mid-transaction: avm_read drops in the next cycle; any in-flight readdatavalid is ignored afterwards.
- FSM states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
- IDLE:
  - A start pulse, or the first post-reset cycle when AUTO_START=1, clears done/id_ok/ts_ok/timeout/id_value/ts_value and moves to ID_REQ.
- xx_REQ:
  - avm_read=1, with avm_address held stable (0 for ID, 1 for TS).
  - The request is accepted in a cycle where avm_read=1 and avm_waitrequest=0.
  - USE_READDATAVALID=0: avm_readdata is captured in the acceptance cycle; go to the next REQ, or DONE.
  - USE_READDATAVALID=1: go to xx_WAIT with avm_read=0 from the next cycle.
- xx_WAIT:
  - Capture on avm_readdatavalid=1, then go to the next REQ or DONE.
  - readdatavalid in any other state is ignored.
- After ID capture: CHECK_TS=1 -> TS_REQ; CHECK_TS=0 -> DONE, with ts_ok=1.
- Compare outputs id_ok/ts_ok are registered one cycle after capture, together with entry to DONE. done=1 and busy=0 in DONE.
- Minimum latency, zero-wait slave, USE_READDATAVALID=0, CHECK_TS=1: start at cycle 0; ID_REQ at 1; TS_REQ at 2; done=1 at cycle 3.
- Timeout counter (16 bit):
  - Cleared on entry to each REQ state; increments each cycle in REQ/WAIT.
  - When the count reaches TIMEOUT_CYCLES, the FSM goes to DONE with timeout=1 and avm_read=0.
  - Flags for words not yet captured remain 0.
- start while busy: ignored. start in DONE: restarts exactly as from IDLE.
- start and a capture in the same cycle: the capture wins; start is not queued.
- busy = FSM not in IDLE/DONE; registered.

Decomposition:
- Shared package sysid_pkg: state enum, address constants ADDR_ID=1'b0 and ADDR_TS=1'b1, timeout counter width.
- One natural sub-module, avalon_read_ctrl: issues a single read, handles waitrequest/readdatavalid and the timeout, and returns data_valid/data/timed_out. The checker FSM instantiates it once and sequences the two addresses.

Test Plan:
- Zero-wait combinational slave (0 / 1586464125), AUTO_START=1, defaults -> done=1 three cycles after reset release; id_ok=1, ts_ok=1, timeout=0; ts_value=1586464125.
- waitrequest held high 4 cycles on each read -> avm_read and avm_address stay stable during stall; done at cycle 11; both ok flags set.
- USE_READDATAVALID=1, readdatavalid 3 cycles after acceptance; spurious readdatavalid in IDLE -> only in-window data captured; results pass.
- Slave returns timestamp 1586464126 -> id_ok=1, ts_ok=0, done=1; ts_value=1586464126.
- waitrequest stuck high, TIMEOUT_CYCLES=10 -> done=1, timeout=1, id_ok=0, ts_ok=0 after 10 cycles in ID_REQ; avm_read=0 afterwards.
- Reset asserted during TS_WAIT, then start pulse -> outputs cleared in the reset cycle; the new check restarts at address 0 and passes.
